// File: rtl/dmem_pkg.sv
// Shared types and widths for the dmem responder slice: FSM states,
// latency-counter width and byte-lane geometry.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  localparam int CNT_W     = 4;
  localparam int BYTE_W    = 8;
  localparam int NUM_LANES = 4;
  localparam int WORD_W    = BYTE_W * NUM_LANES;

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between an initiator (master) and the data-memory
// responder (slave).
interface dmem_if;
  import dmem_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [31:0]          req_addr;
  logic [WORD_W-1:0]    req_wdata;
  logic [NUM_LANES-1:0] req_be;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WORD_W-1:0]    rsp_rdata;
  logic                 rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// Word storage with per-byte write strobes and a registered read port.
// Contents are deliberately left uninitialised.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW         = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk,
  input  logic [AW-1:0]        idx,
  input  logic                 wr_en,
  input  logic [NUM_LANES-1:0] wr_be,
  input  logic [WORD_W-1:0]    wr_data,
  input  logic                 rd_en,
  output logic [WORD_W-1:0]    rd_data
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] rd_data_q;

  // Read data only moves on a read enable, so it stays put while a response waits.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (wr_en && wr_be[i]) begin
        mem_q[idx][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
      end
    end
    if (rd_en) begin
      rd_data_q <= mem_q[idx];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts one request, checks the
// address, and presents a response a fixed number of cycles later.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic   clk,
  input  logic   aresetn,
  dmem_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rd_ok_q, rd_ok_d;
  logic              accept;
  logic              addr_err;
  logic [WORD_W-1:0] rd_data;

  assign accept   = bus.req_valid && req_ready_q;
  // Upper address bits must be zero, so high addresses never alias onto low words.
  assign addr_err = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr[31:AW+2] != '0);

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk     (clk),
    .idx     (bus.req_addr[AW+1:2]),
    .wr_en   (accept && bus.req_we && !addr_err),
    .wr_be   (bus.req_be),
    .wr_data (bus.req_wdata),
    .rd_en   (accept && !bus.req_we && !addr_err),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rsp_err_d = rsp_err_q;
    rd_ok_d   = rd_ok_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rsp_err_d = addr_err;
          rd_ok_d   = !bus.req_we && !addr_err;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      BUSY: begin
        if (cnt_q == CNT_W'(LATENCY - 1)) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Ready waits a full cycle in IDLE, giving the initiator a gap after each response.
    req_ready_d = (state_q == IDLE) && (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_ok_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rd_ok_q     <= rd_ok_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rd_ok_q ? rd_data : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: instance 0 (LATENCY=2, 2048 words) gets directed and random
// traffic, instance 1 (LATENCY=1, 1024 words) gets random back-to-back traffic.
module tb_dmem_responder;

  localparam int NI     = 2;
  localparam int DEPTH0 = 2048;
  localparam int DEPTH1 = 1024;
  localparam int LAT0   = 2;
  localparam int LAT1   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        aresetn_v   [NI];
  logic        req_valid_v [NI];
  logic        req_we_v    [NI];
  logic [31:0] req_addr_v  [NI];
  logic [31:0] req_wdata_v [NI];
  logic [3:0]  req_be_v    [NI];
  logic        rsp_ready_v [NI];
  logic        req_ready_w [NI];
  logic        rsp_valid_w [NI];
  logic        rsp_err_w   [NI];
  logic [31:0] rsp_rdata_w [NI];

  int vectors     = 0;
  int miscompares = 0;
  bit rnd_on      = 0;

  logic [32:0] exp_q0 [$];
  logic [32:0] exp_q1 [$];
  logic [31:0] model0 [int unsigned];
  logic [31:0] model1 [int unsigned];

  dmem_if bus0 ();
  dmem_if bus1 ();

  assign bus0.req_valid = req_valid_v[0];
  assign bus0.req_we    = req_we_v[0];
  assign bus0.req_addr  = req_addr_v[0];
  assign bus0.req_wdata = req_wdata_v[0];
  assign bus0.req_be    = req_be_v[0];
  assign bus0.rsp_ready = rsp_ready_v[0];
  assign req_ready_w[0] = bus0.req_ready;
  assign rsp_valid_w[0] = bus0.rsp_valid;
  assign rsp_err_w[0]   = bus0.rsp_err;
  assign rsp_rdata_w[0] = bus0.rsp_rdata;

  assign bus1.req_valid = req_valid_v[1];
  assign bus1.req_we    = req_we_v[1];
  assign bus1.req_addr  = req_addr_v[1];
  assign bus1.req_wdata = req_wdata_v[1];
  assign bus1.req_be    = req_be_v[1];
  assign bus1.rsp_ready = rsp_ready_v[1];
  assign req_ready_w[1] = bus1.req_ready;
  assign rsp_valid_w[1] = bus1.rsp_valid;
  assign rsp_err_w[1]   = bus1.rsp_err;
  assign rsp_rdata_w[1] = bus1.rsp_rdata;

  dmem_responder #(.DEPTH_WORDS(DEPTH0), .LATENCY(LAT0)) u_dut0 (
    .clk     (clk),
    .aresetn (aresetn_v[0]),
    .bus     (bus0)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH1), .LATENCY(LAT1)) u_dut1 (
    .clk     (clk),
    .aresetn (aresetn_v[1]),
    .bus     (bus1)
  );

  function automatic void checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endfunction

  function automatic void qPush(input int g, input logic [32:0] v);
    if (g == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endfunction

  function automatic int qSize(input int g);
    return (g == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [32:0] qPop(input int g);
    if (g == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  // Reference memory: returns {err, rdata} and applies any legal write.
  function automatic logic [32:0] modelAccess(input int g, input bit we, input logic [31:0] addr,
                                              input logic [31:0] wdata, input logic [3:0] be);
    int unsigned widx  = addr >> 2;
    int unsigned depth = (g == 0) ? DEPTH0 : DEPTH1;
    logic [31:0] word;
    if ((addr % 4) != 0 || widx >= depth) return {1'b1, 32'h0};
    if (g == 0) word = model0.exists(widx) ? model0[widx] : 32'hx;
    else        word = model1.exists(widx) ? model1[widx] : 32'hx;
    if (!we) return {1'b0, word};
    for (int b = 0; b < 4; b++) begin
      if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
    end
    if (g == 0) model0[widx] = word;
    else        model1[widx] = word;
    return {1'b0, 32'h0};
  endfunction

  // Monitor: latency, hold stability, no overlap, and scoreboard pops.
  int          cyc = 0;
  int          acc_n      [NI];
  bit          inflight   [NI];
  bit          prev_valid [NI];
  bit          hold       [NI];
  logic [32:0] held       [NI];

  always @(negedge clk) begin
    cyc++;
    for (int g = 0; g < NI; g++) begin
      if (aresetn_v[g] !== 1'b1) begin
        inflight[g]   = 0;
        prev_valid[g] = 0;
        hold[g]       = 0;
      end else begin
        if (rsp_valid_w[g] && !prev_valid[g]) begin
          checkOutput("rsp has a request", 64'(inflight[g]), 64'd1);
          if (inflight[g]) checkOutput("latency", 64'(cyc - acc_n[g]), 64'(g == 0 ? LAT0 : LAT1));
          inflight[g] = 0;
        end
        if (hold[g]) begin
          checkOutput("held rsp stable", {rsp_valid_w[g], rsp_err_w[g], rsp_rdata_w[g]}, {1'b1, held[g]});
          checkOutput("req_ready while rsp held", 64'(req_ready_w[g]), 64'd0);
        end
        hold[g] = rsp_valid_w[g] && !rsp_ready_v[g];
        held[g] = {rsp_err_w[g], rsp_rdata_w[g]};
        if (rsp_valid_w[g] && rsp_ready_v[g]) begin
          checkOutput("rsp expected", 64'(qSize(g) != 0), 64'd1);
          if (qSize(g) != 0) checkOutput(g == 0 ? "rsp inst0" : "rsp inst1",
                                         {rsp_err_w[g], rsp_rdata_w[g]}, qPop(g));
        end
        if (req_valid_v[g] && req_ready_w[g]) begin
          checkOutput("accept while rsp_valid", 64'(rsp_valid_w[g]), 64'd0);
          acc_n[g]    = cyc;
          inflight[g] = 1;
        end
        prev_valid[g] = rsp_valid_w[g];
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the acceptance edge.
  task automatic applyStimulus(input int g, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
    int t = 0;
    req_valid_v[g] = 1'b1;
    req_we_v[g]    = we;
    req_addr_v[g]  = addr;
    req_wdata_v[g] = wdata;
    req_be_v[g]    = be;
    do begin
      @(negedge clk);
      t++;
    end while (!req_ready_w[g] && t < 200);
    if (!req_ready_w[g]) begin
      $display("[TB] FAIL accept timeout inst%0d: req_ready=0, required 1", g);
      $fatal(1, "[TB] bus stuck");
    end
    qPush(g, modelAccess(g, we, addr, wdata, be));
    @(posedge clk);
    #1;
    req_valid_v[g] = 1'b0;
  endtask

  task automatic waitDrain(input int g);
    int t = 0;
    while ((qSize(g) != 0 || rsp_valid_w[g]) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (qSize(g) != 0 || rsp_valid_w[g]) begin
      $display("[TB] FAIL drain timeout inst%0d: pending=%0d, required 0", g, qSize(g));
      $fatal(1, "[TB] responses stuck");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic randomTraffic(input int g, input int n);
    int unsigned depth = (g == 0) ? DEPTH0 : DEPTH1;
    for (int i = 0; i < 16; i++) applyStimulus(g, 1'b1, 32'h100 + 32'(4*i), $urandom, 4'hF);
    for (int i = 0; i < n; i++) begin
      int k;
      logic [31:0] a;
      k = $urandom_range(0, 9);
      a = 32'h100 + 32'(4 * $urandom_range(0, 15));
      if (k == 0)      a = a + 32'($urandom_range(1, 3));
      else if (k == 1) a = 32'(depth * 4) + 32'(4 * $urandom_range(0, 63));
      else if (k == 2) a = $urandom | 32'h8000_0000;
      applyStimulus(g, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t;
    for (int g = 0; g < NI; g++) begin
      aresetn_v[g]   = 1'b0;
      req_valid_v[g] = 1'b0;
      req_we_v[g]    = 1'b0;
      req_addr_v[g]  = '0;
      req_wdata_v[g] = '0;
      req_be_v[g]    = '0;
      rsp_ready_v[g] = 1'b1;
    end
    @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      checkOutput("reset req_ready", 64'(req_ready_w[g]), 64'd0);
      checkOutput("reset rsp_valid", 64'(rsp_valid_w[g]), 64'd0);
      checkOutput("reset rsp_err",   64'(rsp_err_w[g]),   64'd0);
      checkOutput("reset rsp_rdata", 64'(rsp_rdata_w[g]), 64'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) aresetn_v[g] = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NI; g++) checkOutput("req_ready before first edge", 64'(req_ready_w[g]), 64'd0);
    @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) checkOutput("req_ready after first edge", 64'(req_ready_w[g]), 64'd1);

    applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);  waitDrain(0);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'hF);         waitDrain(0);
    applyStimulus(0, 1'b1, 32'h20, 32'h11223344, 4'hF);  waitDrain(0);
    applyStimulus(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101); waitDrain(0);
    applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'h0);         waitDrain(0);
    applyStimulus(0, 1'b1, 32'h1000, 32'h0BADF00D, 4'hF); waitDrain(0);
    applyStimulus(0, 1'b0, 32'h22, 32'h0, 4'hF);         waitDrain(0);
    applyStimulus(0, 1'b0, 32'(4*DEPTH0), 32'h0, 4'hF);  waitDrain(0);
    applyStimulus(0, 1'b1, 32'h1002, 32'h55, 4'hF);      waitDrain(0);
    applyStimulus(0, 1'b0, 32'h1000, 32'h0, 4'hF);       waitDrain(0);
    applyStimulus(0, 1'b1, 32'h44, 32'h12345678, 4'h0);  waitDrain(0);

    // Back-pressure: response held for several cycles, then released.
    rsp_ready_v[0] = 1'b0;
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'hF);
    t = 0;
    while (!rsp_valid_w[0] && t < 20) begin
      @(negedge clk);
      t++;
    end
    checkOutput("rsp_valid under back-pressure", 64'(rsp_valid_w[0]), 64'd1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    rsp_ready_v[0] = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("req_ready in cycle after rsp", 64'(req_ready_w[0]), 64'd0);
    @(negedge clk);
    checkOutput("req_ready one cycle later", 64'(req_ready_w[0]), 64'd1);
    @(posedge clk);
    #1;

    // Reset while a read is in BUSY: the read must vanish.
    req_we_v[0]    = 1'b0;
    req_addr_v[0]  = 32'h10;
    req_valid_v[0] = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!req_ready_w[0] && t < 20);
    checkOutput("req_ready before reset read", 64'(req_ready_w[0]), 64'd1);
    @(posedge clk);
    #1;
    req_valid_v[0] = 1'b0;
    aresetn_v[0]   = 1'b0;
    #1;
    checkOutput("async reset rsp_valid", 64'(rsp_valid_w[0]), 64'd0);
    checkOutput("async reset req_ready", 64'(req_ready_w[0]), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    aresetn_v[0] = 1'b1;
    @(negedge clk);
    checkOutput("req_ready before edge after reset", 64'(req_ready_w[0]), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("req_ready on first edge after reset", 64'(req_ready_w[0]), 64'd1);
    repeat (4) begin
      @(negedge clk);
      checkOutput("no rsp for discarded read", 64'(rsp_valid_w[0]), 64'd0);
    end
    @(posedge clk);
    #1;

    rnd_on = 1;
    fork
      begin
        fork
          randomTraffic(0, 150);
          randomTraffic(1, 300);
        join
        rnd_on = 0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          rsp_ready_v[0] = ($urandom_range(0, 3) != 0);
          rsp_ready_v[1] = ($urandom_range(0, 3) != 0);
        end
      end
    join
    rsp_ready_v[0] = 1'b1;
    rsp_ready_v[1] = 1'b1;
    waitDrain(0);
    waitDrain(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words stored (power of two, 16..65536).
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to rsp_valid (1..15).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 aresetn  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  write data.
REQ-010 req_be  input  4  byte enables; bit i enables wdata[8i+7:8i].
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  initiator accepts the response.
REQ-013 rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-014 rsp_err  output  1  request rejected (misaligned or out of range).

Function
REQ-015 Request accepted on a rising edge with req_valid=1 and req_ready=1; req_we, req_addr, req_wdata and req_be are captured at that edge.
REQ-016 At most one request is outstanding; req_ready=1 only in state IDLE.
REQ-017 FSM states IDLE, BUSY, RESP; IDLE->BUSY on acceptance; BUSY->RESP when the latency counter reaches LATENCY-1; RESP->IDLE on rsp_valid and rsp_ready both high.
REQ-018 Latency: rsp_valid rises exactly LATENCY cycles after the accepting edge; if LATENCY=1, BUSY lasts zero cycles and IDLE goes directly to RESP.
REQ-019 rsp_valid=1 only in RESP; rsp_rdata and rsp_err are held stable while rsp_valid=1 and rsp_ready=0.
REQ-020 Word index = req_addr[31:2] (byte address divided by 4).
REQ-021 Error if req_addr[1:0] != 0, or if the word index >= DEPTH_WORDS; on error, memory is not modified, rsp_err=1 and rsp_rdata=0.
REQ-022 Write: enabled bytes are updated at the accepting edge; disabled bytes are unchanged; req_be=0000 is a legal no-op write; rsp_rdata=0.
REQ-023 Read: rsp_rdata returns the full word as stored at the accepting edge, regardless of req_be.
REQ-024 A request presented while req_ready=0 is ignored and not queued; the initiator holds it until it is accepted.
REQ-025 No back-to-back acceptance in the cycle of the RESP->IDLE transition; req_ready rises the following cycle (minimum 2-cycle spacing in the LATENCY=1 case).
REQ-026 Addresses wrap at no boundary; the upper address bits take part in the range check (no aliasing).

Reset
REQ-027 aresetn low forces state IDLE, latency counter 0, req_ready=0 and rsp_valid=0, rsp_rdata=0, rsp_err=0, asynchronously.
REQ-028 req_ready becomes 1 on the first rising edge after aresetn deasserts.
REQ-029 Reset mid-transaction discards the outstanding request and drops any pending response; a write already accepted remains in memory.
REQ-030 Memory contents are not initialised by reset.

Structure
REQ-031 Package dmem_pkg holds the state enum (IDLE, BUSY, RESP), the latency-counter width constant and the byte-lane width constant.
REQ-032 Sub-module dmem_array: synchronous word storage with a per-byte write strobe and a registered read port; dmem_responder holds the FSM, the error check and the response registers.

Verification
REQ-033 Reset, then write 0xDEADBEEF to 0x10 with be=1111, then read 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly 2 cycles after each acceptance.
REQ-034 Write 0x11223344 to 0x20 with be=1111, then write 0xAABBCCDD to 0x20 with be=0101, then read 0x20 -> 0x11BB33DD.
REQ-035 Read 0x22 (misaligned) and read 4*DEPTH_WORDS (out of range) -> rsp_err=1 and rsp_rdata=0; write 0x55 to 0x1002 -> rsp_err=1, and word 0x1000 is unchanged on readback.
REQ-036 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stay stable and req_ready=0; rsp_ready=1 -> IDLE, and req_ready=1 the next cycle.
REQ-037 Pull aresetn low while BUSY on a read -> rsp_valid never asserts for that read; after release, req_ready=1 on the first edge.
REQ-038 LATENCY=1 build, random back-to-back traffic against a reference memory model -> every response matches the model, and no acceptance occurs while rsp_valid=1.
